commit_trace_unit: RTL and testbench

- Consumer end of the CPU commit interface (commit, commit_pc, commit_pre_pc), sampled at the W-stage boundary.
- Checks PC-flow continuity: every committed PC must equal the next-PC reported by the previous commit.
- Counts retired instructions and cycles, and buffers each commit into a FIFO trace stream drained by a valid/ready sink (debug port or testbench).

---
 rtl/commit_trace_unit.sv | 159 +++++++++++++++
 tb/tb_commit_trace_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_unit.sv
// commit_trace_unit: checks PC-flow continuity of the commit stream, counts retired
// instructions and cycles, and buffers every commit into a FWFT trace FIFO.
`default_nettype none

module commit_trace_unit #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     commit_i,
  input  logic [31:0]              commit_pc_i,
  input  logic [31:0]              commit_pre_pc_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_pc_o,
  output logic [31:0]              trace_next_pc_o,
  output logic [CNT_W-1:0]         trace_seq_o,
  output logic                     trace_err_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o,
  output logic                     mismatch_o,
  output logic [31:0]              mismatch_pc_o,
  output logic [31:0]              mismatch_expect_o,
  output logic [CNT_W-1:0]         retired_cnt_o,
  output logic [CNT_W-1:0]         cycle_cnt_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] C_PTR1   = AW'(1);
  localparam logic [CNT_W-1:0] C_CNT1 = CNT_W'(1);

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      expected_pc_q;
  logic [CNT_W-1:0] retired_q, cycle_q;
  logic             overflow_q, mismatch_q;
  logic [31:0]      mis_pc_q, mis_exp_q;

  logic [31:0]      mem_pc_q  [DEPTH];
  logic [31:0]      mem_npc_q [DEPTH];
  logic [CNT_W-1:0] mem_seq_q [DEPTH];
  logic             mem_err_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;

  logic w_commit, w_err, w_pop, w_push, w_capture;

  // A clear swallows any simultaneous commit or pop.
  assign w_commit  = commit_i && !clear_i;
  assign w_err     = (state_q != S_SYNC) && (commit_pc_i != expected_pc_q);
  assign w_pop     = (count_q != '0) && trace_ready_i && !clear_i;
  assign w_push    = w_commit && ((count_q < C_DEPTH) || w_pop);
  assign w_capture = w_commit && (state_q == S_RUN) && w_err;

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_SYNC;
    end else if (commit_i) begin
      case (state_q)
        S_SYNC:  state_d = S_RUN;
        S_RUN:   state_d = w_err ? S_ERR : S_RUN;
        default: state_d = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expected_pc_q <= RESET_PC;
      retired_q     <= '0;
      cycle_q       <= '0;
      overflow_q    <= 1'b0;
      mismatch_q    <= 1'b0;
      mis_pc_q      <= '0;
      mis_exp_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]  <= '0;
        mem_npc_q[i] <= '0;
        mem_seq_q[i] <= '0;
        mem_err_q[i] <= 1'b0;
      end
    end else if (clear_i) begin
      retired_q  <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
      mis_pc_q   <= '0;
      mis_exp_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (cycle_q != '1) cycle_q <= cycle_q + C_CNT1;
      if (w_commit) begin
        expected_pc_q <= commit_pre_pc_i;
        if (retired_q != '1) retired_q <= retired_q + C_CNT1;
        if (!w_push) overflow_q <= 1'b1;
      end
      if (w_capture) begin
        mismatch_q <= 1'b1;
        mis_pc_q   <= commit_pc_i;
        mis_exp_q  <= expected_pc_q;
      end
      if (w_push) begin
        mem_pc_q[wr_ptr_q]  <= commit_pc_i;
        mem_npc_q[wr_ptr_q] <= commit_pre_pc_i;
        mem_seq_q[wr_ptr_q] <= retired_q;
        mem_err_q[wr_ptr_q] <= w_err;
        wr_ptr_q            <= wr_ptr_q + C_PTR1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + C_PTR1;
      count_q <= count_d;
    end
  end

  assign trace_valid_o     = (count_q != '0);
  assign trace_pc_o        = mem_pc_q[rd_ptr_q];
  assign trace_next_pc_o   = mem_npc_q[rd_ptr_q];
  assign trace_seq_o       = mem_seq_q[rd_ptr_q];
  assign trace_err_o       = mem_err_q[rd_ptr_q];
  assign fifo_count_o      = count_q;
  assign overflow_o        = overflow_q;
  assign mismatch_o        = mismatch_q;
  assign mismatch_pc_o     = mis_pc_q;
  assign mismatch_expect_o = mis_exp_q;
  assign retired_cnt_o     = retired_q;
  assign cycle_cnt_o       = cycle_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_unit.sv
// tb_commit_trace_unit: scoreboard bench for commit_trace_unit plus a CNT_W=4 saturation instance.
`default_nettype none

module tb_commit_trace_unit;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk, rst;
  logic clear_i, commit_i, trace_ready_i;
  logic [31:0] commit_pc_i, commit_pre_pc_i;
  logic trace_valid_o, trace_err_o, overflow_o, mismatch_o;
  logic [31:0] trace_pc_o, trace_next_pc_o, mismatch_pc_o, mismatch_expect_o;
  logic [31:0] trace_seq_o, retired_cnt_o, cycle_cnt_o;
  logic [3:0]  fifo_count_o;

  logic c4_commit;
  logic c4_valid, c4_err, c4_ovf, c4_mis;
  logic [31:0] c4_pc, c4_npc, c4_mpc, c4_mexp;
  logic [3:0]  c4_seq, c4_ret, c4_cyc, c4_count;

  commit_trace_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .commit_i(commit_i),
    .commit_pc_i(commit_pc_i), .commit_pre_pc_i(commit_pre_pc_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_next_pc_o(trace_next_pc_o),
    .trace_seq_o(trace_seq_o), .trace_err_o(trace_err_o),
    .fifo_count_o(fifo_count_o), .overflow_o(overflow_o), .mismatch_o(mismatch_o),
    .mismatch_pc_o(mismatch_pc_o), .mismatch_expect_o(mismatch_expect_o),
    .retired_cnt_o(retired_cnt_o), .cycle_cnt_o(cycle_cnt_o)
  );

  commit_trace_unit #(.DEPTH(4), .RESET_PC(RESET_PC), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clear_i(1'b0), .commit_i(c4_commit),
    .commit_pc_i(32'h0), .commit_pre_pc_i(32'h0),
    .trace_valid_o(c4_valid), .trace_ready_i(1'b0),
    .trace_pc_o(c4_pc), .trace_next_pc_o(c4_npc),
    .trace_seq_o(c4_seq), .trace_err_o(c4_err),
    .fifo_count_o(c4_count[2:0]), .overflow_o(c4_ovf), .mismatch_o(c4_mis),
    .mismatch_pc_o(c4_mpc), .mismatch_expect_o(c4_mexp),
    .retired_cnt_o(c4_ret), .cycle_cnt_o(c4_cyc)
  );
  assign c4_count[3] = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] seq;
    logic        err;
  } entry_t;

  entry_t sb_q[$];

  typedef enum int { M_SYNC, M_RUN, M_ERR } mstate_t;
  mstate_t     m_state;
  logic [31:0] m_exp, m_retired, m_cycle, m_mpc, m_mexp;
  logic        m_ovf, m_mis;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_status();
    check("retired", retired_cnt_o, m_retired);
    check("cycles", cycle_cnt_o, m_cycle);
    check("count", fifo_count_o, sb_q.size());
    check("overflow", overflow_o, m_ovf);
    check("mismatch", mismatch_o, m_mis);
    check("mis_pc", mismatch_pc_o, m_mpc);
    check("mis_expect", mismatch_expect_o, m_mexp);
  endtask

  // One clock cycle: drive inputs, predict, compare head on pop, then check status.
  task automatic step(input logic c, input logic [31:0] pc, input logic [31:0] npc,
                      input logic rdy, input logic clr);
    entry_t e;
    logic   pop, err;
    commit_i        = c;
    commit_pc_i     = pc;
    commit_pre_pc_i = npc;
    trace_ready_i   = rdy;
    clear_i         = clr;
    @(negedge clk);
    check("valid", trace_valid_o, sb_q.size() != 0);
    pop = (sb_q.size() != 0) && rdy && !clr;
    if (pop) begin
      e = sb_q[0];
      check("head_pc", trace_pc_o, e.pc);
      check("head_npc", trace_next_pc_o, e.npc);
      check("head_seq", trace_seq_o, e.seq);
      check("head_err", trace_err_o, e.err);
    end
    if (clr) begin
      sb_q.delete();
      m_state = M_SYNC; m_retired = 0; m_cycle = 0;
      m_ovf = 0; m_mis = 0; m_mpc = 0; m_mexp = 0;
    end else begin
      if (m_cycle != 32'hFFFF_FFFF) m_cycle++;
      if (pop) void'(sb_q.pop_front());
      if (c) begin
        err = (m_state != M_SYNC) && (pc != m_exp);
        if (sb_q.size() < DEPTH) begin
          e.pc = pc; e.npc = npc; e.seq = m_retired; e.err = err;
          sb_q.push_back(e);
        end else begin
          m_ovf = 1;
        end
        if (m_state == M_RUN && err) begin
          m_mis = 1; m_mpc = pc; m_mexp = m_exp;
        end
        if (m_state == M_SYNC)    m_state = M_RUN;
        else if (err)             m_state = M_ERR;
        m_exp = npc;
        if (m_retired != 32'hFFFF_FFFF) m_retired++;
      end
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2*DEPTH + 4 && sb_q.size() != 0; i++) idle(1'b1);
    check("drained", fifo_count_o, 0);
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    commit_i = 0; clear_i = 0; trace_ready_i = 0; c4_commit = 0;
    commit_pc_i = 0; commit_pre_pc_i = 0;
    #1;
    check("rst_valid", trace_valid_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_retired", retired_cnt_o, 0);
    check("rst_mismatch", mismatch_o, 0);
    check("rst_trace_pc", trace_pc_o, 0);
    sb_q.delete();
    m_state = M_RUN; m_exp = RESET_PC; m_retired = 0; m_cycle = 0;
    m_ovf = 0; m_mis = 0; m_mpc = 0; m_mexp = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    c4_commit = 0;
    commit_i = 0; clear_i = 0; trace_ready_i = 0;
    commit_pc_i = 0; commit_pre_pc_i = 0;

    // Basic in-order flow
    do_reset();
    step(1, 32'h8000_0000, 32'h8000_0004, 1, 0);
    step(1, 32'h8000_0004, 32'h8000_0010, 1, 0);
    check("retired_two", retired_cnt_o, 2);
    drain();

    // First commit off the reset PC, then a second mismatch with frozen capture
    do_reset();
    step(1, 32'h8000_0008, 32'h8000_000C, 0, 0);
    check("mis_pc_first", mismatch_pc_o, 32'h8000_0008);
    check("mis_exp_first", mismatch_expect_o, 32'h8000_0000);
    check("err_head", trace_err_o, 1);
    step(1, 32'h8000_000C, 32'h8000_0020, 0, 0);
    step(1, 32'h1111_0000, 32'h1111_0004, 0, 0);
    check("mis_pc_frozen", mismatch_pc_o, 32'h8000_0008);
    drain();

    // Overflow with ready low
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++)
      step(1, RESET_PC + 32'(4*i), RESET_PC + 32'(4*i + 4), 0, 0);
    check("ovf_count", fifo_count_o, DEPTH);
    check("ovf_flag", overflow_o, 1);
    check("ovf_retired", retired_cnt_o, DEPTH + 2);
    drain();

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1, RESET_PC + 32'(4*i), RESET_PC + 32'(4*i + 4), 0, 0);
    step(1, RESET_PC + 32'(4*DEPTH), RESET_PC + 32'(4*DEPTH + 4), 1, 0);
    check("full_pp_count", fifo_count_o, DEPTH);
    check("full_pp_ovf", overflow_o, 0);
    check("full_pp_head", trace_seq_o, 1);
    drain();

    // Clear in S_ERR with a simultaneous commit and pop, then resync
    do_reset();
    step(1, 32'h8000_0040, 32'h8000_0044, 0, 0);
    step(1, 32'h8000_0044, 32'h8000_0048, 0, 0);
    step(1, 32'h8000_0048, 32'h8000_004C, 1, 1);
    check("clr_count", fifo_count_o, 0);
    check("clr_retired", retired_cnt_o, 0);
    check("clr_cycles", cycle_cnt_o, 0);
    step(1, 32'h8000_1234, 32'h8000_2000, 0, 0);
    step(1, 32'h8000_2000, 32'h8000_2004, 0, 0);
    step(1, 32'h8000_3000, 32'h8000_3004, 0, 0);
    check("resync_mis_exp", mismatch_expect_o, 32'h8000_2004);
    idle(1);
    idle(1);
    drain();

    // Counter saturation on the narrow instance
    do_reset();
    c4_commit = 1;
    for (int i = 0; i < 20; i++) idle(1);
    c4_commit = 0;
    check("c4_cycles_sat", c4_cyc, 4'hF);
    check("c4_retired_sat", c4_ret, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
